// File: rtl/apb_pkg.sv
// Shared APB completer definitions: bus widths, FSM encoding and the latched
// setup-phase request.
package apb_pkg;
  localparam int APB_DATA_W  = 32;
  localparam int APB_SEL_W   = 3;
  localparam int APB_ERR_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic                  err;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;
endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: load on setup, decrement per access cycle,
// flags for zero and for the final wait cycle.
module apb_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (load_i)               cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == W'(1));
endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer on one bridge select line: register bank with a read-only ID
// register, programmable wait states and error response.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int                    SEL_INDEX   = 0,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'h0000_0019
) (
  input  logic                  Pclk,
  input  logic                  Preset,
  input  logic [APB_SEL_W-1:0]  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [31:0]           Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  apb_state_e            state_q;
  apb_req_t              req_q;
  logic [AW-1:0]         idx_q;
  logic [APB_DATA_W-1:0] prdata_q;
  logic                  pready_q, pslverr_q;
  logic [APB_DATA_W-1:0] regs_q [NUM_REGS];

  logic sel, setup, access;
  assign sel    = Pselx[SEL_INDEX];
  assign setup  = sel && !Penable;
  assign access = sel && Penable;

  logic [AW-1:0] idx_in;
  logic          err_in;
  assign idx_in = Paddr[AW+1:2];
  assign err_in = (|Paddr[APB_ERR_MSB:AW+2]) || (Pwrite && idx_in == '0);

  logic [CW-1:0] cnt;
  logic          cnt_zero, cnt_last;

  apb_wait_counter #(.W(CW)) u_wait_cnt (
    .clk_i      (Pclk),
    .rst_i      (Preset),
    .load_i     (state_q == ST_IDLE && setup),
    .load_val_i (CW'(WAIT_STATES)),
    .dec_i      (state_q == ST_WAIT && access),
    .clr_i      (state_q == ST_WAIT && !sel),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero),
    .last_o     (cnt_last)
  );

  // Zero-wait transfers enter DONE straight from setup, so the response is
  // built from the live bus rather than the latched request.
  logic                  enter_done, nx_err, nx_wr;
  logic [AW-1:0]         nx_idx;
  logic [APB_DATA_W-1:0] nx_rdata;

  always_comb begin
    enter_done = 1'b0;
    nx_err     = req_q.err;
    nx_wr      = req_q.write;
    nx_idx     = idx_q;
    if (state_q == ST_IDLE) begin
      enter_done = setup && (WAIT_STATES == 0);
      nx_err     = err_in;
      nx_wr      = Pwrite;
      nx_idx     = idx_in;
    end else if (state_q == ST_WAIT) begin
      enter_done = access && cnt_last;
    end
    if (nx_err)              nx_rdata = '0;
    else if (nx_idx == '0)   nx_rdata = ID_VALUE;
    else                     nx_rdata = regs_q[nx_idx];
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      idx_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      if (enter_done) begin
        pready_q  <= 1'b1;
        pslverr_q <= nx_err;
        if (!nx_wr) prdata_q <= nx_rdata;
      end
      unique case (state_q)
        ST_IDLE: if (setup) begin
          req_q   <= '{write: Pwrite, err: err_in, wdata: Pwdata};
          idx_q   <= idx_in;
          state_q <= (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
        end
        ST_WAIT: begin
          if (!sel)            state_q <= ST_IDLE;
          else if (enter_done) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Commit only if the bridge still holds the access phase at the final edge.
  logic wr_en;
  assign wr_en = (state_q == ST_DONE) && access && req_q.write && !req_q.err;

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[idx_q] <= req_q.wdata;
    end
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;

  logic unused_ok;
  assign unused_ok = ^{Paddr[31:APB_ERR_MSB+1], Paddr[1:0], Pselx, cnt_zero};
endmodule
